// File: rtl/uart_tx_axis.sv
// uart_tx_axis: UART transmitter fed by an AXI4-Stream slave port.
// Frame on tx: start bit (0), DATA_BITS data bits LSB first, optional parity
// bit, stop bit(s) (1). Every bit lasts BAUD_DIV = CLK_FREQ/BAUD clocks.
// tx is registered from the current state, so the start bit appears on the
// clock after the handshake edge.
// Build option: define UART_TX_STOP2_EN to send two stop bits per frame.
// PARITY values other than "even"/"odd" transmit without a parity bit.
module uart_tx_axis #(
  parameter int    CLK_FREQ  = 50_000_000,
  parameter int    BAUD      = 115200,
  parameter int    DATA_BITS = 8,
  parameter string PARITY    = "even"
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int BAUD_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BIT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam bit PAR_EN   = (PARITY == "even") || (PARITY == "odd");
  localparam bit PAR_ODD  = (PARITY == "odd");

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY_S,
    STOP
  } state_e;

  state_e               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 baud_end;

  // Last clock of the current bit period.
  assign baud_end = (baud_q == BAUD_W'(BAUD_DIV - 1));

  // Handshake and status flags are decoded from the state register only,
  // so there is no combinational path from tvalid to tready.
  assign s_axis_tready = (state_q == IDLE);
  assign tx_busy       = (state_q != IDLE);
  assign tx            = tx_q;

  // State and datapath registers; reset forces the line idle-high at once.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  // NOTE: the shift register is a handful of flops, not a memory array, so
  // it is cleared with the rest of the state to give a fully defined reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state, bit timing and line-level decode for the frame sequencer.
  // NOTE: every variable gets a default before the case statement so no
  // path through the block can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = 1'b1;

    if (state_q != IDLE) begin
      baud_d = baud_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (s_axis_tvalid) begin
          shift_d = s_axis_tdata;
          par_d   = (^s_axis_tdata) ^ PAR_ODD;
          state_d = START;
        end
      end

      START: begin
        tx_d = 1'b0;
        if (baud_end) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end

      DATA: begin
        tx_d = shift_q[0];
        if (baud_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = PAR_EN ? PARITY_S : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      PARITY_S: begin
        tx_d = par_q;
        if (baud_end) begin
          state_d = STOP;
        end
      end

      STOP: begin
        tx_d = 1'b1;
        if (baud_end) begin
`ifdef UART_TX_STOP2_EN
          // bit_cnt is idle in STOP, so it counts the two stop bits.
          if (bit_q == '0) begin
            bit_d = BIT_W'(1);
          end else begin
            bit_d   = '0;
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_axis.sv
// tb_uart_tx_axis: directed bench for uart_tx_axis.
// Three instances (even, odd, none parity) share clk/rst. A negedge logger
// records tx/tready/busy per clock; cycle n holds the values after posedge n.
// Expected frames are written out by hand as {stop, parity, data, start}.
`timescale 1ns/1ps
module tb_uart_tx_axis;

  localparam int LOG  = 8192;
  localparam int EVEN = 0;
  localparam int ODD  = 1;
  localparam int NONE = 2;
`ifdef UART_TX_STOP2_EN
  localparam int SB = 2;
`else
  localparam int SB = 1;
`endif
  localparam int FE = 10 + SB;  // frame bits with parity
  localparam int FN = 9 + SB;   // frame bits without parity

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tdata  [3];
  logic       tvalid [3];
  logic       tready [3];
  logic       tx     [3];
  logic       busy   [3];

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  logic log_tx   [3][LOG];
  logic log_rdy  [3][LOG];
  logic log_busy [3][LOG];

  uart_tx_axis #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY("even")) u_even (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata[EVEN]), .s_axis_tvalid(tvalid[EVEN]),
    .s_axis_tready(tready[EVEN]), .tx(tx[EVEN]), .tx_busy(busy[EVEN]));

  uart_tx_axis #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY("odd")) u_odd (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata[ODD]), .s_axis_tvalid(tvalid[ODD]),
    .s_axis_tready(tready[ODD]), .tx(tx[ODD]), .tx_busy(busy[ODD]));

  uart_tx_axis #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY("none")) u_none (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata[NONE]), .s_axis_tvalid(tvalid[NONE]),
    .s_axis_tready(tready[NONE]), .tx(tx[NONE]), .tx_busy(busy[NONE]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < LOG) begin
      for (int i = 0; i < 3; i++) begin
        log_tx[i][cyc]   <= tx[i];
        log_rdy[i][cyc]  <= tready[i];
        log_busy[i][cyc] <= busy[i];
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // Offer one word; h is the cycle index of the handshake edge.
  task automatic do_hs(input int idx, input logic [7:0] d, output int h, output bit ok);
    ok = 1'b0;
    h  = 0;
    @(negedge clk);
    tdata[idx]  = d;
    tvalid[idx] = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (tready[idx]) begin
        @(posedge clk);
        #1;
        h           = cyc;
        tvalid[idx] = 1'b0;
        tdata[idx]  = ~d;
        ok          = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tvalid[idx] = 1'b0;
  endtask

  // Hold tvalid high and feed up to three words, recording handshake cycles.
  task automatic stream(input int idx, input logic [7:0] w0, input logic [7:0] w1,
                        input logic [7:0] w2, input int n,
                        output int h0, output int h1, output int h2, output int got);
    logic [7:0] w [3];
    w[0] = w0; w[1] = w1; w[2] = w2;
    got = 0; h0 = 0; h1 = 0; h2 = 0;
    @(negedge clk);
    tdata[idx]  = w[0];
    tvalid[idx] = 1'b1;
    for (int i = 0; i < 1000 && got < n; i++) begin
      if (tready[idx]) begin
        @(posedge clk);
        #1;
        case (got)
          0:       h0 = cyc;
          1:       h1 = cyc;
          default: h2 = cyc;
        endcase
        got++;
        if (got < n) tdata[idx] = w[got];
        else         tvalid[idx] = 1'b0;
      end
      @(negedge clk);
    end
    tvalid[idx] = 1'b0;
  endtask

  task automatic wait_log(input int target);
    while (cyc < target + 2) @(posedge clk);
  endtask

  // Count clocks in the frame starting after handshake h that differ from exp.
  task automatic frame_errs(input int idx, input int h, input logic [11:0] exp,
                            input int nbits, output int nbad);
    nbad = 0;
    for (int k = 0; k < nbits; k++)
      for (int j = 0; j < 10; j++)
        if (log_tx[idx][h + 1 + 10 * k + j] !== exp[k]) nbad++;
  endtask

  function automatic logic mid(input int idx, input int h, input int k);
    return log_tx[idx][h + 5 + 10 * k];
  endfunction

  function automatic int high_run(input int idx, input int from);
    int run = 0;
    for (int n = from; n > 0; n--) begin
      if (log_tx[idx][n] !== 1'b1) break;
      run++;
    end
    return run;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tvalid[i] = 1'b0;
      tdata[i]  = 8'h00;
    end
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tx[i] !== 1'b1) begin failures++; $display("FAIL reset_tx[%0d]: got %b want 1", i, tx[i]); end
      checks++;
      if (tready[i] !== 1'b1) begin failures++; $display("FAIL reset_tready[%0d]: got %b want 1", i, tready[i]); end
      checks++;
      if (busy[i] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d]: got %b want 0", i, busy[i]); end
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tx[i] !== 1'b1 || tready[i] !== 1'b1 || busy[i] !== 1'b0) begin
        failures++;
        $display("FAIL idle_after_reset[%0d]: tx=%b tready=%b busy=%b want 1 1 0", i, tx[i], tready[i], busy[i]);
      end
    end
  endtask

  task automatic test_even_frame();
    int h; bit ok; int nbad;
    do_hs(EVEN, 8'h55, h, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL even_hs: got no handshake want one"); return; end
    wait_log(h + 10 * FE + 2);
    checks++;
    if (log_tx[EVEN][h] !== 1'b1) begin failures++; $display("FAIL even_tx_hs_clk: got %b want 1", log_tx[EVEN][h]); end
    checks++;
    if (log_tx[EVEN][h + 1] !== 1'b0) begin failures++; $display("FAIL even_start_edge: got %b want 0", log_tx[EVEN][h + 1]); end
    frame_errs(EVEN, h, {2'b11, 1'b0, 8'h55, 1'b0}, FE, nbad);
    checks++;
    if (nbad !== 0) begin failures++; $display("FAIL even_frame_55: got %0d bad clks want 0", nbad); end
    checks++;
    if (mid(EVEN, h, 9) !== 1'b0) begin failures++; $display("FAIL even_parity_55: got %b want 0", mid(EVEN, h, 9)); end
    checks++;
    if (log_rdy[EVEN][h + 10 * FE - 1] !== 1'b0) begin failures++; $display("FAIL even_tready_early: got 1 want 0"); end
    checks++;
    if (log_rdy[EVEN][h + 10 * FE] !== 1'b1) begin failures++; $display("FAIL even_tready_return: got %b want 1", log_rdy[EVEN][h + 10 * FE]); end
    checks++;
    if (log_busy[EVEN][h - 1] !== 1'b0 || log_busy[EVEN][h] !== 1'b1) begin
      failures++;
      $display("FAIL even_busy_rise: got %b%b want 01", log_busy[EVEN][h - 1], log_busy[EVEN][h]);
    end
    checks++;
    if (log_busy[EVEN][h + 10 * FE - 1] !== 1'b1 || log_busy[EVEN][h + 10 * FE] !== 1'b0) begin
      failures++;
      $display("FAIL even_busy_fall: got %b%b want 10", log_busy[EVEN][h + 10 * FE - 1], log_busy[EVEN][h + 10 * FE]);
    end
  endtask

  task automatic test_parity();
    int h; bit ok; int nbad;
    logic [7:0] seq;
    logic       par_exp;
    for (int idx = EVEN; idx <= ODD; idx++) begin
      par_exp = (idx == EVEN) ? 1'b1 : 1'b0;
      do_hs(idx, 8'hA7, h, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL parity_hs[%0d]: got no handshake want one", idx); continue; end
      wait_log(h + 10 * FE + 2);
      seq = '0;
      for (int k = 1; k <= 8; k++) seq = {seq[6:0], mid(idx, h, k)};
      checks++;
      if (seq !== 8'b1110_0101) begin failures++; $display("FAIL parity_data_order[%0d]: got %b want 11100101", idx, seq); end
      checks++;
      if (mid(idx, h, 9) !== par_exp) begin failures++; $display("FAIL parity_bit_A7[%0d]: got %b want %b", idx, mid(idx, h, 9), par_exp); end
      frame_errs(idx, h, {2'b11, par_exp, 8'hA7, 1'b0}, FE, nbad);
      checks++;
      if (nbad !== 0) begin failures++; $display("FAIL parity_frame[%0d]: got %0d bad clks want 0", idx, nbad); end
    end
  endtask

  task automatic test_back_to_back();
    int h0, h1, h2, got, nbad, run;
    stream(NONE, 8'h00, 8'hFF, 8'h3C, 3, h0, h1, h2, got);
    checks++;
    if (got !== 3) begin failures++; $display("FAIL b2b_count: got %0d handshakes want 3", got); return; end
    wait_log(h2 + 10 * FN + 2);
    checks++;
    if (h1 - h0 !== 10 * FN + 1) begin failures++; $display("FAIL b2b_spacing_01: got %0d want %0d", h1 - h0, 10 * FN + 1); end
    checks++;
    if (h2 - h1 !== 10 * FN + 1) begin failures++; $display("FAIL b2b_spacing_12: got %0d want %0d", h2 - h1, 10 * FN + 1); end
    frame_errs(NONE, h0, {3'b111, 8'h00, 1'b0}, FN, nbad);
    checks++;
    if (nbad !== 0) begin failures++; $display("FAIL b2b_frame_00: got %0d bad clks want 0", nbad); end
    frame_errs(NONE, h1, {3'b111, 8'hFF, 1'b0}, FN, nbad);
    checks++;
    if (nbad !== 0) begin failures++; $display("FAIL b2b_frame_FF: got %0d bad clks want 0", nbad); end
    frame_errs(NONE, h2, {3'b111, 8'h3C, 1'b0}, FN, nbad);
    checks++;
    if (nbad !== 0) begin failures++; $display("FAIL b2b_frame_3C: got %0d bad clks want 0", nbad); end
    run = high_run(NONE, h1);
    checks++;
    if (run !== 10 * SB + 1) begin failures++; $display("FAIL b2b_idle_gap: got %0d high clks want %0d", run, 10 * SB + 1); end
  endtask

  task automatic test_busy_tvalid();
    int h; bit ok; int nbad; int bad_idle;
    do_hs(EVEN, 8'h3C, h, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL busy_hs: got no handshake want one"); return; end
    while (cyc < h + 35) @(negedge clk);
    tdata[EVEN]  = 8'hC3;
    tvalid[EVEN] = 1'b1;
    repeat (3) @(negedge clk);
    tvalid[EVEN] = 1'b0;
    wait_log(h + 10 * FE + 300);
    frame_errs(EVEN, h, {2'b11, 1'b0, 8'h3C, 1'b0}, FE, nbad);
    checks++;
    if (nbad !== 0) begin failures++; $display("FAIL busy_frame_3C: got %0d bad clks want 0", nbad); end
    bad_idle = 0;
    for (int n = h + 10 * FE + 1; n < h + 10 * FE + 300; n++)
      if (log_tx[EVEN][n] !== 1'b1 || log_busy[EVEN][n] !== 1'b0) bad_idle++;
    checks++;
    if (bad_idle !== 0) begin failures++; $display("FAIL busy_no_extra_frame: got %0d non-idle clks want 0", bad_idle); end
  endtask

  task automatic test_reset_mid_frame();
    int h, r; bit ok; int nbad; int bad_idle;
    do_hs(EVEN, 8'h0F, h, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rstmid_hs: got no handshake want one"); return; end
    while (cyc < h + 45) @(negedge clk);
    checks++;
    if (tx[EVEN] !== 1'b1) begin failures++; $display("FAIL rstmid_pre_bit3: got %b want 1", tx[EVEN]); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (tx[EVEN] !== 1'b1 || busy[EVEN] !== 1'b0 || tready[EVEN] !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_async: tx=%b busy=%b tready=%b want 1 0 1", tx[EVEN], busy[EVEN], tready[EVEN]);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    r = cyc;
    wait_log(r + 150);
    bad_idle = 0;
    for (int n = r; n < r + 150; n++)
      if (log_tx[EVEN][n] !== 1'b1 || log_busy[EVEN][n] !== 1'b0) bad_idle++;
    checks++;
    if (bad_idle !== 0) begin failures++; $display("FAIL rstmid_dropped: got %0d non-idle clks want 0", bad_idle); end
    @(negedge clk);
    rst          = 1'b1;
    tdata[EVEN]  = 8'h81;
    tvalid[EVEN] = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    r   = cyc;
    @(posedge clk);
    #1;
    tvalid[EVEN] = 1'b0;
    tdata[EVEN]  = 8'h00;
    h = r + 1;
    wait_log(h + 10 * FE + 2);
    checks++;
    if (log_busy[EVEN][h] !== 1'b1) begin failures++; $display("FAIL rstmid_first_edge_accept: got busy=%b want 1", log_busy[EVEN][h]); end
    frame_errs(EVEN, h, {2'b11, 1'b0, 8'h81, 1'b0}, FE, nbad);
    checks++;
    if (nbad !== 0) begin failures++; $display("FAIL rstmid_frame_81: got %0d bad clks want 0", nbad); end
  endtask

  task automatic test_stop_bits();
    int h0, h1, h2, got, nbad, run;
    stream(EVEN, 8'h01, 8'h01, 8'h00, 2, h0, h1, h2, got);
    checks++;
    if (got !== 2) begin failures++; $display("FAIL stop_count: got %0d handshakes want 2", got); return; end
    wait_log(h1 + 10 * FE + 2);
    checks++;
    if (h1 - h0 !== 10 * FE + 1) begin failures++; $display("FAIL stop_spacing: got %0d want %0d", h1 - h0, 10 * FE + 1); end
    frame_errs(EVEN, h0, {2'b11, 1'b1, 8'h01, 1'b0}, FE, nbad);
    checks++;
    if (nbad !== 0) begin failures++; $display("FAIL stop_frame_01: got %0d bad clks want 0", nbad); end
    run = high_run(EVEN, h1);
    checks++;
    if (run !== 10 * SB + 11) begin failures++; $display("FAIL stop_high_run: got %0d high clks want %0d", run, 10 * SB + 11); end
  endtask

  initial begin
    test_reset();
    test_even_frame();
    test_parity();
    test_back_to_back();
    test_busy_tvalid();
    test_reset_mid_frame();
    test_stop_bits();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
